// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC generator.
package pc_pkg;

   localparam int unsigned INSN_BYTES = 4;

   typedef enum logic [2:0] {
      SRC_SEQ   = 3'd0,
      SRC_HOLD  = 3'd1,
      SRC_JUMP  = 3'd2,
      SRC_RET   = 3'd3,
      SRC_REDIR = 3'd4,
      SRC_TRAP  = 3'd5,
      SRC_RESET = 3'd6
   } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: overwrites the oldest entry when full, and push+pop
// together replaces the top entry in place.
module ras_stack #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [XLEN-1:0]          i_wdata,
   output logic [XLEN-1:0]          o_top,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_ovf,
   output logic                     o_unf
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;

   logic [PTR_W-1:0] w_ptr_d;
   logic [CNT_W-1:0] w_count_d;
   logic             w_ovf_d;
   logic             w_unf_d;
   logic             w_we;
   logic [PTR_W-1:0] w_waddr;
   logic             w_empty;
   logic             w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   always_comb begin
      w_ptr_d   = r_ptr;
      w_count_d = r_count;
      w_ovf_d   = 1'b0;
      w_unf_d   = 1'b0;
      w_we      = 1'b0;
      w_waddr   = r_ptr + PTR_W'(1);
      if (i_clear) begin
         w_ptr_d   = '0;
         w_count_d = '0;
      end else if (i_push && i_pop && !w_empty) begin
         w_we    = 1'b1;
         w_waddr = r_ptr;
      end else begin
         if (i_pop) begin
            if (w_empty) begin
               w_unf_d = 1'b1;
            end else begin
               w_ptr_d   = r_ptr - PTR_W'(1);
               w_count_d = r_count - CNT_W'(1);
            end
         end
         // Pop is only non-empty here when push is idle, so pointers never collide.
         if (i_push) begin
            w_we    = 1'b1;
            w_ptr_d = r_ptr + PTR_W'(1);
            if (w_full) begin
               w_ovf_d = 1'b1;
            end else begin
               w_count_d = r_count + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_ptr   <= w_ptr_d;
         r_count <= w_count_d;
         r_ovf   <= w_ovf_d;
         r_unf   <= w_unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_we) begin
         r_mem[w_waddr] <= i_wdata;
      end
   end

   assign o_top   = r_mem[r_ptr];
   assign o_count = r_count;
   assign o_ovf   = r_ovf;
   assign o_unf   = r_unf;

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: picks trap/redirect/hold/return/jump/sequential next PC and
// drives the return-address stack.
module pc_fetch_gen
   import pc_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned FETCH_W   = 1,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [XLEN-1:0]              i_pc_start,
   input  logic                         i_stall,
   input  logic                         i_trap_valid,
   input  logic [XLEN-1:0]              i_trap_target,
   input  logic                         i_redir_valid,
   input  logic [XLEN-1:0]              i_redir_target,
   input  logic                         i_pred_jump,
   input  logic                         i_pred_call,
   input  logic [XLEN-1:0]              i_pred_target,
   input  logic [XLEN-1:0]              i_ras_push_addr,
   input  logic                         i_pred_ret,
   output logic [XLEN-1:0]              o_pc_out,
   output logic [XLEN-1:0]              o_pc_next,
   output logic [XLEN-1:0]              o_pc_seq,
   output pc_src_e                      o_pc_src,
   output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
   output logic                         o_ras_overflow,
   output logic                         o_ras_underflow
);

   localparam int unsigned   GRP_BYTES  = INSN_BYTES * FETCH_W;
   localparam logic [XLEN-1:0] GRP_MASK   = ~XLEN'(GRP_BYTES - 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

   logic [XLEN-1:0] r_pc;
   pc_src_e         r_src;

   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_pc_next;
   pc_src_e         w_src_next;
   logic            w_push;
   logic            w_pop;
   logic            w_clear;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_empty;

   assign w_pc_seq = (r_pc & GRP_MASK) + XLEN'(GRP_BYTES);

   always_comb begin
      w_pc_next  = w_pc_seq;
      w_src_next = SRC_SEQ;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_clear    = 1'b0;
      if (!rst_n) begin
         w_pc_next  = i_pc_start;
         w_src_next = SRC_RESET;
      end else if (i_trap_valid) begin
         w_pc_next  = i_trap_target & ALIGN_MASK;
         w_src_next = SRC_TRAP;
         w_clear    = 1'b1;
      end else if (i_redir_valid) begin
         w_pc_next  = i_redir_target & ALIGN_MASK;
         w_src_next = SRC_REDIR;
      end else if (i_stall) begin
         w_pc_next  = r_pc;
         w_src_next = SRC_HOLD;
      end else if (i_pred_ret) begin
         // A call in the same group as a return swaps the top entry.
         w_pop  = 1'b1;
         w_push = i_pred_jump && i_pred_call;
         if (!w_ras_empty) begin
            w_pc_next  = w_ras_top & ALIGN_MASK;
            w_src_next = SRC_RET;
         end
      end else if (i_pred_jump) begin
         w_pc_next  = i_pred_target & ALIGN_MASK;
         w_src_next = SRC_JUMP;
         w_push     = i_pred_call;
      end
   end

   always_ff @(posedge clk) begin
      r_pc  <= w_pc_next;
      r_src <= w_src_next;
   end

   ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .i_wdata (i_ras_push_addr),
      .o_top   (w_ras_top),
      .o_count (o_ras_count),
      .o_ovf   (o_ras_overflow),
      .o_unf   (o_ras_underflow)
   );

   assign w_ras_empty = (o_ras_count == '0);
   assign o_pc_out    = r_pc;
   assign o_pc_next   = w_pc_next;
   assign o_pc_seq    = w_pc_seq;
   assign o_pc_src    = r_src;

endmodule
